mod_counter_ud: RTL and testbench

Parametrised modulo-N up/down counter with synchronous load, terminal-count and cascade-carry outputs, and an optional enable prescaler. It is the next-generation general-purpose counter for timers, BCD digit chains and display scanners. Instances cascade directly: a digit's `carry` drives the next digit's `en`.

---
 rtl/mod_counter_pkg.sv | 51 +++++
 rtl/mod_prescaler.sv | 46 ++++
 rtl/mod_counter_ud.sv | 126 ++++++++++++
 tb/tb_mod_counter_ud.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// mod_counter_pkg
// Shared definitions for the modulo-N up/down counter:
//   DIR_UP / DIR_DOWN  direction encoding of the `up` input
//   MAX_W              widest counter supported by the shared step function
//   ext_t              working width for the step arithmetic (MAX_W+1 bits)
//   step_t             next count value plus wrap flag
//   next_mod()         one modulo step in either direction
// -----------------------------------------------------------------------------
package mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MAX_W = 32;

  // One bit wider than any legal count, so MODULUS = 2**WIDTH and the
  // +1 / -1 intermediates can never overflow.
  typedef logic [MAX_W:0] ext_t;

  typedef struct packed {
    ext_t value;
    logic wrap;
  } step_t;

  // Wrap is detected by explicit compare against the modulus bounds, never by
  // relying on natural binary rollover.
  function automatic step_t next_mod(input ext_t cnt, input logic up,
                                     input ext_t modulus);
    step_t r;
    r.value = cnt;
    r.wrap  = 1'b0;
    if (up == DIR_UP) begin
      if (cnt == modulus - ext_t'(1)) begin
        r.value = '0;
        r.wrap  = 1'b1;
      end else begin
        r.value = cnt + ext_t'(1);
      end
    end else begin
      if (cnt == '0) begin
        r.value = modulus - ext_t'(1);
        r.wrap  = 1'b1;
      end else begin
        r.value = cnt - ext_t'(1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_prescaler.sv
// -----------------------------------------------------------------------------
// mod_prescaler
// Enable divider for mod_counter_ud. Counts cycles with `en` high from 0 to
// PRESCALE-1; `en_eff` pulses on the enabled cycle where the phase reaches
// PRESCALE-1, after which the phase returns to 0. The phase holds while `en`
// is low. Only compiled when MODCNT_PRESCALE_EN is defined, since it is only
// instantiated in that build.
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high reset (phase <= 0)
//   clr     in   synchronous phase clear (driven by counter load)
//   en      in   raw enable
//   en_eff  out  divided enable (combinational from phase and en)
// -----------------------------------------------------------------------------
`ifdef MODCNT_PRESCALE_EN
module mod_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic en_eff
);

  // PRESCALE = 1 still needs a 1-bit register; it simply stays at 0.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(PRESCALE - 1);

  logic [PW-1:0] r_phase;
  logic          w_last;

  assign w_last = (r_phase == LAST_PHASE);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_phase <= '0;
    end else if (en) begin
      r_phase <= w_last ? '0 : r_phase + PW'(1);
    end
  end

  assign en_eff = en & w_last;

endmodule
`endif

// File: rtl/mod_counter_ud.sv
// -----------------------------------------------------------------------------
// mod_counter_ud
// Parametrised modulo-N up/down counter with synchronous load, terminal count,
// cascade carry and registered wrap / load-error pulses. Cascade by driving
// the next digit's `en` from this digit's `carry`.
// Optional feature: define MODCNT_PRESCALE_EN to divide `en` by PRESCALE
// through mod_prescaler; otherwise the effective enable is `en` itself.
// Parameters:
//   WIDTH     counter width (<= MAX_W)
//   MODULUS   count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   PRESCALE  enable divide ratio (>= 1), used only with MODCNT_PRESCALE_EN
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   en        in   count enable
//   up        in   1 = increment, 0 = decrement
//   load      in   synchronous load (beats enable)
//   load_val  in   value to load; out-of-range loads 0 and flags load_err
//   count     out  registered count
//   tc        out  terminal count for the current direction (combinational)
//   carry     out  tc & effective enable (combinational)
//   wrap      out  registered one-cycle pulse after a wrap
//   load_err  out  registered one-cycle pulse after an out-of-range load
// -----------------------------------------------------------------------------
module mod_counter_ud
  import mod_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             carry,
  output logic             wrap,
  output logic             load_err
);

  if (WIDTH < 1 || WIDTH > MAX_W || MODULUS < 2 ||
      longint'(MODULUS) > (longint'(1) << WIDTH) || PRESCALE < 1) begin : g_bad_param
    $error("mod_counter_ud: illegal WIDTH/MODULUS/PRESCALE combination");
  end

  localparam ext_t             MOD_EXT = ext_t'(MODULUS);
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_load_err;

  ext_t  w_cnt_ext;
  ext_t  w_load_ext;
  step_t w_step;
  logic  w_load_ok;
  logic  w_en_eff;
  logic  w_tc;
  logic  w_unused_hi;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_cnt_ext                = '0;
    w_cnt_ext[WIDTH-1:0]     = r_count;
    w_load_ext               = '0;
    w_load_ext[WIDTH-1:0]    = load_val;
  end

  assign w_step    = next_mod(w_cnt_ext, up, MOD_EXT);
  assign w_load_ok = (w_load_ext < MOD_EXT);

  // Upper bits of the step result are always zero for a legal count.
  assign w_unused_hi = ^w_step.value[MAX_W:WIDTH];

`ifdef MODCNT_PRESCALE_EN
  mod_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clr    (load),
    .en     (en),
    .en_eff (w_en_eff)
  );
`else
  assign w_en_eff = en;
`endif

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: reset is synchronous; only the control state is cleared, there is
  // no storage array that would need (or should get) a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else if (load) begin
      r_count    <= w_load_ok ? load_val : '0;
      r_load_err <= ~w_load_ok;
      r_wrap     <= 1'b0;
    end else if (w_en_eff) begin
      r_count    <= w_step.value[WIDTH-1:0];
      r_wrap     <= w_step.wrap;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end
  end

  // Terminal count follows `up` immediately, whether or not enabled.
  assign w_tc = (up == DIR_UP) ? (r_count == LAST) : (r_count == '0);

  assign count    = r_count;
  assign tc       = w_tc;
  assign carry    = w_tc & w_en_eff;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_mod_counter_ud.sv
// -----------------------------------------------------------------------------
// tb_mod_counter_ud
// Self-checking bench for mod_counter_ud (WIDTH=4, MODULUS=10). A reference
// model built from modular arithmetic predicts each cycle's outputs; the
// driver pushes predictions into a scoreboard queue and an independent
// monitor pops and compares them. A cascaded pair (low carry -> high en) is
// checked alongside the main instance.
// -----------------------------------------------------------------------------
module tb_mod_counter_ud;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;
`ifdef MODCNT_PRESCALE_EN
  localparam int PRESCALE = 3;
`else
  localparam int PRESCALE = 1;
`endif

  typedef struct { int count; bit wrap; bit lerr; int pre; } mstate_t;
  typedef struct { bit reset; bit en; bit up; bit load; int lv; } min_t;
  typedef struct { int count; bit tc; bit carry; bit wrap; bit lerr; } mobs_t;
  typedef struct { mobs_t m; mobs_t lo; mobs_t hi; } rec_t;

  logic clk = 1'b0;
  logic reset, en, up, load, casc_en;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count, lo_count, hi_count;
  logic tc, carry, wrap, load_err;
  logic lo_carry, lo_wrap, hi_wrap;
  logic unused_lo_tc, unused_lo_lerr, unused_hi_tc, unused_hi_carry, unused_hi_lerr;

  int n_vec = 0;
  int n_err = 0;

  rec_t    sb[$];
  mstate_t s_m, s_lo, s_hi;
  bit      known = 1'b0;

  always #5 clk = ~clk;

  mod_counter_ud #(.WIDTH(WIDTH), .MODULUS(MODULUS), .PRESCALE(PRESCALE)) u_dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count), .tc(tc), .carry(carry), .wrap(wrap), .load_err(load_err));

  mod_counter_ud #(.WIDTH(WIDTH), .MODULUS(MODULUS), .PRESCALE(PRESCALE)) u_lo (
    .clk(clk), .reset(reset), .en(casc_en), .up(1'b1), .load(1'b0), .load_val('0),
    .count(lo_count), .tc(unused_lo_tc), .carry(lo_carry), .wrap(lo_wrap),
    .load_err(unused_lo_lerr));

  mod_counter_ud #(.WIDTH(WIDTH), .MODULUS(MODULUS), .PRESCALE(PRESCALE)) u_hi (
    .clk(clk), .reset(reset), .en(lo_carry), .up(1'b1), .load(1'b0), .load_val('0),
    .count(hi_count), .tc(unused_hi_tc), .carry(unused_hi_carry), .wrap(hi_wrap),
    .load_err(unused_hi_lerr));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: observation for the current cycle plus next state.
  function automatic void model_step(input mstate_t s, input min_t i,
                                     output mobs_t o, output mstate_t n);
    bit en_eff;
    o.count = s.count;
    o.wrap  = s.wrap;
    o.lerr  = s.lerr;
    o.tc    = i.up ? (s.count == MODULUS - 1) : (s.count == 0);
    en_eff  = i.en && (s.pre == PRESCALE - 1);
    o.carry = o.tc && en_eff;
    n = s;
    n.wrap = 1'b0;
    n.lerr = 1'b0;
    if (i.reset) begin
      n.count = 0;
      n.pre   = 0;
    end else if (i.load) begin
      n.pre = 0;
      if (i.lv < MODULUS) n.count = i.lv;
      else begin
        n.count = 0;
        n.lerr  = 1'b1;
      end
    end else begin
      if (i.en) n.pre = (s.pre + 1) % PRESCALE;
      if (en_eff) begin
        if (i.up) n.count = (s.count + 1) % MODULUS;
        else      n.count = (s.count + MODULUS - 1) % MODULUS;
        n.wrap = i.up ? (s.count == MODULUS - 1) : (s.count == 0);
      end
    end
  endfunction

  task automatic step(input bit r, input bit e, input bit u, input bit l,
                      input int lv, input bit ce);
    min_t    im, il, ih;
    rec_t    rec;
    mstate_t nm, nl, nh;
    @(negedge clk);
    reset = r; en = e; up = u; load = l; load_val = WIDTH'(lv); casc_en = ce;
    im = '{reset: r, en: e, up: u, load: l, lv: lv};
    il = '{reset: r, en: ce, up: 1'b1, load: 1'b0, lv: 0};
    model_step(s_m, im, rec.m, nm);
    model_step(s_lo, il, rec.lo, nl);
    ih = '{reset: r, en: rec.lo.carry, up: 1'b1, load: 1'b0, lv: 0};
    model_step(s_hi, ih, rec.hi, nh);
    if (known) sb.push_back(rec);
    s_m = nm; s_lo = nl; s_hi = nh;
    if (r) known = 1'b1;
  endtask

  // Monitor: compares the DUT against the oldest prediction each cycle.
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("count",    32'(count),    e.m.count);
        check("tc",       32'(tc),       32'(e.m.tc));
        check("carry",    32'(carry),    32'(e.m.carry));
        check("wrap",     32'(wrap),     32'(e.m.wrap));
        check("load_err", 32'(load_err), 32'(e.m.lerr));
        check("lo_count", 32'(lo_count), e.lo.count);
        check("lo_carry", 32'(lo_carry), 32'(e.lo.carry));
        check("lo_wrap",  32'(lo_wrap),  32'(e.lo.wrap));
        check("hi_count", 32'(hi_count), e.hi.count);
        check("hi_wrap",  32'(hi_wrap),  32'(e.hi.wrap));
      end
    end
  end

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0; casc_en = 1'b0;
    s_m = '{count: 0, wrap: 1'b0, lerr: 1'b0, pre: 0};
    s_lo = s_m;
    s_hi = s_m;

    // Reset, then count up through a full wrap.
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    for (int k = 0; k < 12 * PRESCALE; k++) step(0, 1, 1, 0, 0, 0);

    // Load 2, then count down across zero: 2,1,0,9,8.
    step(0, 0, 1, 1, 2, 0);
    for (int k = 0; k < 5 * PRESCALE; k++) step(0, 1, 0, 0, 0, 0);

    // Load beats enable; out-of-range load clears and flags.
    step(0, 1, 0, 1, 7, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 12, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);

    // Reset mid-count with en high, then hold.
    step(0, 0, 1, 1, 5, 0);
    step(1, 1, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0, 0);

    // Cascade: 100 enables bring both digits back to 0.
    step(1, 0, 1, 0, 0, 1);
    for (int k = 0; k < 100; k++)
      step(0, 1'($urandom), 1'($urandom), 1'b0, 0, 1'b1);
`ifndef MODCNT_PRESCALE_EN
    @(posedge clk);
    #1;
    check("cascade_100_lo", 32'(lo_count), 32'd0);
    check("cascade_100_hi", 32'(hi_count), 32'd0);
`endif

    // Randomised traffic.
    for (int k = 0; k < 800; k++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, 1'($urandom),
           $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 8);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #3;
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d predictions left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
